// File: rtl/axis_conv_input_packer.sv
// axis_conv_input_packer
// Serial-to-parallel AXI-Stream packer. Collects ROWS consecutive pixel words
// (one per S beat) into a single wide M beat, framing a block of cols x cin wide
// beats and flagging the final one with tlast.
//
// Ports
//   aclk, areset              clock, synchronous active-high reset
//   start, cols_1, cin_1      block launch pulse and block geometry (sampled on start)
//   S_AXIS_tdata/tvalid/tready  narrow pixel stream in
//   M_AXIS_tdata[ROWS-1:0]      wide beat out, lane r = row r
//   M_AXIS_tvalid/tready/tlast  wide stream handshake and end-of-block flag
//   busy                      high from start accept until the final beat is taken
module axis_conv_input_packer #(
  parameter int unsigned DATA_WIDTH         = 16,
  parameter int unsigned CONV_UNITS         = 8,
  parameter int unsigned KERNEL_H_MAX       = 3,
  parameter int unsigned CIN_COUNTER_WIDTH  = 5,
  parameter int unsigned COLS_COUNTER_WIDTH = 10,
  localparam int unsigned ROWS              = CONV_UNITS + KERNEL_H_MAX - 1
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic                          start,
  input  logic [COLS_COUNTER_WIDTH-1:0] cols_1,
  input  logic [CIN_COUNTER_WIDTH-1:0]  cin_1,
  input  logic [DATA_WIDTH-1:0]         S_AXIS_tdata,
  input  logic                          S_AXIS_tvalid,
  output logic                          S_AXIS_tready,
  output logic [DATA_WIDTH-1:0]         M_AXIS_tdata [ROWS-1:0],
  output logic                          M_AXIS_tvalid,
  input  logic                          M_AXIS_tready,
  output logic                          M_AXIS_tlast,
  output logic                          busy
);

  localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e                        state_q, state_d;
  logic [COLS_COUNTER_WIDTH-1:0] cols_1_q, cols_1_d;
  logic [CIN_COUNTER_WIDTH-1:0]  cin_1_q, cin_1_d;
  logic [ROW_W-1:0]              row_cnt_q, row_cnt_d;
  logic [CIN_COUNTER_WIDTH-1:0]  cin_cnt_q, cin_cnt_d;
  logic [COLS_COUNTER_WIDTH-1:0] col_cnt_q, col_cnt_d;
  logic [DATA_WIDTH-1:0]         pack_q [ROWS-2:0];
  logic [DATA_WIDTH-1:0]         pack_d [ROWS-2:0];
  logic [DATA_WIDTH-1:0]         out_q  [ROWS-1:0];
  logic [DATA_WIDTH-1:0]         out_d  [ROWS-1:0];
  logic                          tvalid_q, tvalid_d;
  logic                          tlast_q, tlast_d;
  logic                          busy_q, busy_d;

  logic row_last_c;
  logic cin_last_c;
  logic col_last_c;
  logic s_ready_c;
  logic s_hs_c;
  logic m_hs_c;

  // Final row of a wide beat may only be taken once the output register has room.
  assign row_last_c = (row_cnt_q == ROW_W'(ROWS - 1));
  assign cin_last_c = (cin_cnt_q == cin_1_q);
  assign col_last_c = (col_cnt_q == cols_1_q);
  assign s_ready_c  = (state_q == ST_RUN) && !(row_last_c && tvalid_q && !M_AXIS_tready);
  assign s_hs_c     = S_AXIS_tvalid && s_ready_c;
  assign m_hs_c     = tvalid_q && M_AXIS_tready;

  assign S_AXIS_tready = s_ready_c;
  assign M_AXIS_tdata  = out_q;
  assign M_AXIS_tvalid = tvalid_q;
  assign M_AXIS_tlast  = tlast_q;
  assign busy          = busy_q;

  // State and datapath registers.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= ST_IDLE;
      cols_1_q  <= '0;
      cin_1_q   <= '0;
      row_cnt_q <= '0;
      cin_cnt_q <= '0;
      col_cnt_q <= '0;
      pack_q    <= '{default: '0};
      out_q     <= '{default: '0};
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cols_1_q  <= cols_1_d;
      cin_1_q   <= cin_1_d;
      row_cnt_q <= row_cnt_d;
      cin_cnt_q <= cin_cnt_d;
      col_cnt_q <= col_cnt_d;
      pack_q    <= pack_d;
      out_q     <= out_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state, counters, pack and output register loading.
  always_comb begin
    state_d   = state_q;
    cols_1_d  = cols_1_q;
    cin_1_d   = cin_1_q;
    row_cnt_d = row_cnt_q;
    cin_cnt_d = cin_cnt_q;
    col_cnt_d = col_cnt_q;
    pack_d    = pack_q;
    out_d     = out_q;
    tvalid_d  = tvalid_q;
    tlast_d   = tlast_q;

    // Beat consumed downstream; a same-edge reload below takes priority.
    if (m_hs_c) begin
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_RUN;
          cols_1_d  = cols_1;
          cin_1_d   = cin_1;
          row_cnt_d = '0;
          cin_cnt_d = '0;
          col_cnt_d = '0;
        end
      end

      ST_RUN: begin
        if (s_hs_c) begin
          if (row_last_c) begin
            for (int unsigned r = 0; r < ROWS - 1; r++) begin
              out_d[r] = pack_q[r];
            end
            out_d[ROWS-1] = S_AXIS_tdata;
            tvalid_d      = 1'b1;
            tlast_d       = cin_last_c && col_last_c;
            row_cnt_d     = '0;
            if (cin_last_c) begin
              cin_cnt_d = '0;
              if (col_last_c) begin
                col_cnt_d = '0;
                state_d   = ST_DRAIN;
              end else begin
                col_cnt_d = col_cnt_q + COLS_COUNTER_WIDTH'(1);
              end
            end else begin
              cin_cnt_d = cin_cnt_q + CIN_COUNTER_WIDTH'(1);
            end
          end else begin
            for (int unsigned r = 0; r < ROWS - 1; r++) begin
              if (row_cnt_q == ROW_W'(r)) begin
                pack_d[r] = S_AXIS_tdata;
              end
            end
            row_cnt_d = row_cnt_q + ROW_W'(1);
          end
        end
      end

      ST_DRAIN: begin
        if (m_hs_c && tlast_q) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

endmodule
